// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register-file responder.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Register storage: one byte-strobed synchronous write port, one asynchronous read port.
module axi_lite_reg_bank #(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Async read lets a same-edge read observe the pre-write contents.
    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite responder over a register bank; independent write and read channel FSMs.
module axi_lite_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * STRB_W);

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return off[LSB +: IDX_W];
    endfunction

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic                  aw_have, w_have;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic                  wr_in_range, rd_in_range;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [DATA_WIDTH-1:0] bank_rdata;

    // Whichever of AW/W handshakes last supplies its fields straight from the bus.
    always_comb begin
        aw_hs       = awvalid && awready;
        w_hs        = wvalid && wready;
        ar_hs       = arvalid && arready;
        wr_addr     = aw_hs ? awaddr : aw_addr_q;
        wr_data     = w_hs ? wdata : w_data_q;
        wr_strb     = w_hs ? wstrb : w_strb_q;
        commit      = (wr_state == W_IDLE) && (aw_hs || aw_have) && (w_hs || w_have);
        wr_in_range = addr_in_range(wr_addr);
        rd_in_range = addr_in_range(araddr);
    end

    axi_lite_reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clk  (aclk),
        .reset(areset),
        .we   (commit && wr_in_range),
        .waddr(addr_index(wr_addr)),
        .wdata(wr_data),
        .wstrb(wr_strb),
        .raddr(addr_index(araddr)),
        .rdata(bank_rdata)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state  <= W_IDLE;
            awready   <= 1'b1;
            wready    <= 1'b1;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            aw_have   <= 1'b0;
            w_have    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (commit) begin
                        bvalid   <= 1'b1;
                        bresp    <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                        awready  <= 1'b0;
                        wready   <= 1'b0;
                        aw_have  <= 1'b0;
                        w_have   <= 1'b0;
                        wr_state <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_have   <= 1'b1;
                            aw_addr_q <= awaddr;
                            awready   <= 1'b0;
                        end
                        if (w_hs) begin
                            w_have   <= 1'b1;
                            w_data_q <= wdata;
                            w_strb_q <= wstrb;
                            wready   <= 1'b0;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        awready  <= 1'b1;
                        wready   <= 1'b1;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state <= R_IDLE;
            arready  <= 1'b1;
            rvalid   <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata    <= rd_in_range ? bank_rdata : '0;
                        rresp    <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        rvalid   <= 1'b1;
                        arready  <= 1'b0;
                        rd_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid   <= 1'b0;
                        arready  <= 1'b1;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed self-checking bench for axi_lite_regfile_slave (default parameters).
module tb_axi_lite_regfile_slave;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_regs [16];

    always #5 aclk = ~aclk;

    axi_lite_regfile_slave #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS  (16),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // AW presented from cycle aw_dly, W from cycle w_dly; then collect B with bready high.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_ok = 0;
        bit w_ok  = 0;
        bit got   = 0;
        logic aw_rdy, w_rdy;
        int cyc = 0;
        resp = 2'bxx;
        awaddr = addr;
        wdata  = data;
        wstrb  = strb;
        while (!(aw_ok && w_ok) && cyc < 40) begin
            awvalid = !aw_ok && (cyc >= aw_dly);
            wvalid  = !w_ok && (cyc >= w_dly);
            aw_rdy  = awready;
            w_rdy   = wready;
            tick();
            if (awvalid && aw_rdy) aw_ok = 1;
            if (wvalid && w_rdy)   w_ok  = 1;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_ok && w_ok)) check("write_handshake_timeout", 32'd0, 32'd1);
        bready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bvalid) begin
                resp = bresp;
                got  = 1;
            end
            tick();
        end
        bready = 1'b0;
        if (!got) check("bvalid_timeout", 32'd0, 32'd1);
    endtask

    // lat counts samples after the AR handshake before rvalid was seen (0 = next cycle).
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        bit ar_ok = 0;
        bit got   = 0;
        logic ar_rdy;
        data = 'x;
        resp = 2'bxx;
        lat  = -1;
        araddr = addr;
        for (int i = 0; i < 40 && !ar_ok; i++) begin
            arvalid = 1'b1;
            ar_rdy  = arready;
            tick();
            if (ar_rdy) ar_ok = 1;
        end
        arvalid = 1'b0;
        if (!ar_ok) check("read_handshake_timeout", 32'd0, 32'd1);
        rready = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rvalid) begin
                data = rdata;
                resp = rresp;
                lat  = i;
                got  = 1;
            end
            tick();
        end
        rready = 1'b0;
        if (!got) check("rvalid_timeout", 32'd0, 32'd1);
    endtask

    logic [1:0]  resp, resp2;
    logic [31:0] data, hold_data;
    int          lat, lat2;

    initial begin
        areset  = 1'b1;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
        repeat (3) tick();
        areset = 1'b0;

        check("rst_awready", {31'd0, awready}, 32'd1);
        check("rst_wready", {31'd0, wready}, 32'd1);
        check("rst_arready", {31'd0, arready}, 32'd1);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_bresp_rresp", {28'd0, bresp, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);

        // Reset during a write with only AW accepted: write is abandoned.
        awaddr = 32'h0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("midwr_awready_low", {31'd0, awready}, 32'd0);
        areset = 1'b1;
        repeat (2) tick();
        areset = 1'b0;
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("midrst_bvalid", {31'd0, bvalid}, 32'd0);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("postrst_bvalid", {31'd0, bvalid}, 32'd0);
        check("postrst_readys", {29'd0, awready, wready, arready}, 32'h7);
        axi_read(32'h0, data, resp, lat);
        check("postrst_rd0_data", data, 32'h0);
        check("postrst_rd0_resp", {30'd0, resp}, 32'd0);

        // AW then W three cycles later.
        axi_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 3, resp);
        exp_regs[1] = 32'hDEAD_BEEF;
        check("aw_first_bresp", {30'd0, resp}, 32'd0);
        axi_read(32'h4, data, resp, lat);
        check("aw_first_rdata", data, 32'hDEAD_BEEF);
        check("rd_latency", lat, 0);

        // W before AW.
        axi_write(32'h10, 32'h1234_5678, 4'hF, 3, 0, resp);
        exp_regs[4] = 32'h1234_5678;
        check("w_first_bresp", {30'd0, resp}, 32'd0);
        axi_read(32'h10, data, resp, lat);
        check("w_first_rdata", data, 32'h1234_5678);

        // Byte strobes; low address bits ignored on the read.
        axi_write(32'h8, 32'h1122_3344, 4'hF, 0, 0, resp);
        axi_write(32'h8, 32'hAABB_CCDD, 4'b0101, 1, 0, resp);
        exp_regs[2] = 32'h11BB_33DD;
        axi_read(32'hB, data, resp, lat);
        check("strobe_rdata", data, 32'h11BB_33DD);

        // Out of range on both channels.
        axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, resp);
        check("oor_bresp", {30'd0, resp}, 32'h2);
        axi_read(32'h40, data, resp, lat);
        check("oor_rresp", {30'd0, resp}, 32'h2);
        check("oor_rdata", data, 32'h0);
        axi_read(32'hFFFF_FFFC, data, resp, lat);
        check("oor_high_rresp", {30'd0, resp}, 32'h2);
        axi_read(32'h3C, data, resp, lat);
        check("last_reg_rresp", {30'd0, resp}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            axi_read(32'(i * 4), data, resp, lat);
            check($sformatf("regs_after_oor_%0d", i), data, exp_regs[i]);
        end

        // Write backpressure: B held, second AW offered but not taken.
        awaddr = 32'h14; awvalid = 1'b1;
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        exp_regs[5] = 32'hCAFE_F00D;
        awaddr = 32'h18; awvalid = 1'b1; wdata = 32'h5555_5555; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", {31'd0, bvalid}, 32'd1);
            check("bp_bresp", {30'd0, bresp}, 32'd0);
            check("bp_aw_w_ready", {30'd0, awready, wready}, 32'd0);
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("bp_bvalid_clear", {31'd0, bvalid}, 32'd0);
        check("bp_ready_back", {30'd0, awready, wready}, 32'h3);
        axi_read(32'h18, data, resp, lat);
        check("bp_no_extra_write", data, 32'h0);

        // Read backpressure.
        araddr = 32'h14; arvalid = 1'b1;
        tick();
        araddr = 32'h4;
        hold_data = rdata;
        check("bp_rdata", hold_data, 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid", {31'd0, rvalid}, 32'd1);
            check("bp_rdata_stable", rdata, 32'hCAFE_F00D);
            check("bp_arready", {31'd0, arready}, 32'd0);
            tick();
        end
        arvalid = 1'b0;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("bp_rvalid_clear", {31'd0, rvalid}, 32'd0);
        check("bp_arready_back", {31'd0, arready}, 32'd1);

        // Same-edge write commit and read of one register.
        axi_write(32'hC, 32'h1, 4'hF, 0, 0, resp);
        fork
            axi_write(32'hC, 32'h2, 4'hF, 0, 0, resp2);
            axi_read(32'hC, data, resp, lat2);
        join
        check("collide_old", data, 32'h1);
        check("collide_bresp", {30'd0, resp2}, 32'd0);
        axi_read(32'hC, data, resp, lat);
        check("collide_new", data, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
